// File: rtl/if_id_stage_pkg.sv
// Shared pipeline definitions: IF/ID stage state encodings and the NOP word.
package if_id_stage_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_HOLD   = 2'b01,
    ST_BUBBLE = 2'b10
  } stage_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/if_id_stage_if.sv
// Fetch-to-decode bundle: hazard controls, fetch slot in, decode slot and
// performance counters out. The stage itself is the slave.
interface if_id_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             EN;
  logic             stall;
  logic             flush;
  logic [XLEN-1:0]  PC_in;
  logic [XLEN-1:0]  inst_in;
  logic             valid_in;
  logic             cnt_clr;
  logic [XLEN-1:0]  PC_out;
  logic [XLEN-1:0]  inst_out;
  logic             valid_out;
  logic [1:0]       state_out;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             stall_timeout;

  modport master (
    output EN, stall, flush, PC_in, inst_in, valid_in, cnt_clr,
    input  PC_out, inst_out, valid_out, state_out, stall_cnt, flush_cnt, stall_timeout
  );

  modport slave (
    input  EN, stall, flush, PC_in, inst_in, valid_in, cnt_clr,
    output PC_out, inst_out, valid_out, state_out, stall_cnt, flush_cnt, stall_timeout
  );
endinterface

// File: rtl/if_id_stage_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Count up on i_inc, stick at all-ones, zero on i_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && !(&r_count)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with freeze/hold/bubble control, stall and flush
// performance counters, and a sticky watchdog on long stall runs.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int CNT_W     = 32,
  parameter int STALL_MAX = 16
) (
  input logic          clk,
  input logic          rst,
  if_id_stage_if.slave if_bus
);

  localparam logic [CNT_W-1:0] RUN_TRIP = CNT_W'(STALL_MAX - 1);

  stage_state_e     r_state;
  stage_state_e     w_state_nxt;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_inst;
  logic             r_valid;
  logic             r_timeout;
  logic             w_hold;
  logic             w_bubble;
  logic             w_load;
  logic [CNT_W-1:0] w_stall_cnt;
  logic [CNT_W-1:0] w_flush_cnt;
  logic [CNT_W-1:0] w_run_len;

  // Action decode in priority order: freeze, hold, bubble, load.
  always_comb begin
    w_hold      = 1'b0;
    w_bubble    = 1'b0;
    w_load      = 1'b0;
    w_state_nxt = r_state;
    if (if_bus.EN) begin
      if (if_bus.stall) begin
        w_hold      = 1'b1;
        w_state_nxt = ST_HOLD;
      end else if (if_bus.flush) begin
        w_bubble    = 1'b1;
        w_state_nxt = ST_BUBBLE;
      end else begin
        w_load      = 1'b1;
        w_state_nxt = ST_RUN;
      end
    end
  end

  // Stage state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Pipeline registers: load from fetch, or insert a NOP bubble; hold/freeze keep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= '0;
      r_inst  <= XLEN'(NOP);
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_pc    <= if_bus.PC_in;
      r_inst  <= if_bus.inst_in;
      r_valid <= if_bus.valid_in;
    end else if (w_bubble) begin
      r_pc    <= '0;
      r_inst  <= XLEN'(NOP);
      r_valid <= 1'b0;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_hold),
    .i_clr   (if_bus.cnt_clr),
    .o_count (w_stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_bubble),
    .i_clr   (if_bus.cnt_clr),
    .o_count (w_flush_cnt)
  );

  // Consecutive-hold run length; any load or bubble breaks the run.
  sat_counter #(.WIDTH(CNT_W)) u_run_len (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_hold),
    .i_clr   (if_bus.cnt_clr | w_load | w_bubble),
    .o_count (w_run_len)
  );

  // Watchdog trips on the hold edge that brings the run length to STALL_MAX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timeout <= 1'b0;
    end else if (if_bus.cnt_clr) begin
      r_timeout <= 1'b0;
    end else if (w_hold && (w_run_len >= RUN_TRIP)) begin
      r_timeout <= 1'b1;
    end
  end

  assign if_bus.PC_out        = r_pc;
  assign if_bus.inst_out      = r_inst;
  assign if_bus.valid_out     = r_valid;
  assign if_bus.state_out     = r_state;
  assign if_bus.stall_cnt     = w_stall_cnt;
  assign if_bus.flush_cnt     = w_flush_cnt;
  assign if_bus.stall_timeout = r_timeout;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: one instance with a short watchdog, one with
// narrow counters for saturation, both driven with the same stimulus.
module tb_if_id_stage;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  if_id_stage_if #(.XLEN(32), .CNT_W(32)) bus_a ();
  if_id_stage_if #(.XLEN(32), .CNT_W(4))  bus_b ();

  if_id_stage #(.XLEN(32), .CNT_W(32), .STALL_MAX(4)) dut_a (
    .clk    (clk),
    .rst    (rst),
    .if_bus (bus_a)
  );

  if_id_stage #(.XLEN(32), .CNT_W(4), .STALL_MAX(15)) dut_b (
    .clk    (clk),
    .rst    (rst),
    .if_bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic en, input logic st, input logic fl,
                       input logic [31:0] pc, input logic [31:0] inst,
                       input logic v, input logic clr);
    bus_a.EN = en;  bus_a.stall = st;  bus_a.flush = fl;
    bus_a.PC_in = pc;  bus_a.inst_in = inst;  bus_a.valid_in = v;  bus_a.cnt_clr = clr;
    bus_b.EN = en;  bus_b.stall = st;  bus_b.flush = fl;
    bus_b.PC_in = pc;  bus_b.inst_in = inst;  bus_b.valid_in = v;  bus_b.cnt_clr = clr;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("rst_pc",      bus_a.PC_out,        64'h0);
    chk("rst_inst",    bus_a.inst_out,      64'h13);
    chk("rst_valid",   bus_a.valid_out,     64'h0);
    chk("rst_state",   bus_a.state_out,     64'h0);
    chk("rst_scnt",    bus_a.stall_cnt,     64'h0);
    chk("rst_fcnt",    bus_a.flush_cnt,     64'h0);
    chk("rst_timeout", bus_a.stall_timeout, 64'h0);
    step(2);
    rst = 1'b0;

    drive(1'b1, 1'b0, 1'b0, 32'h100, 32'h0050_0093, 1'b1, 1'b0);
    step(1);
    chk("load_pc",    bus_a.PC_out,    64'h100);
    chk("load_inst",  bus_a.inst_out,  64'h0050_0093);
    chk("load_valid", bus_a.valid_out, 64'h1);
    chk("load_state", bus_a.state_out, 64'h0);

    drive(1'b1, 1'b0, 1'b0, 32'h104, 32'h0060_0113, 1'b1, 1'b0);
    step(1);
    drive(1'b1, 1'b1, 1'b0, 32'h999, 32'hdead_beef, 1'b0, 1'b0);
    step(3);
    chk("hold_pc",      bus_a.PC_out,        64'h104);
    chk("hold_inst",    bus_a.inst_out,      64'h0060_0113);
    chk("hold_valid",   bus_a.valid_out,     64'h1);
    chk("hold_state",   bus_a.state_out,     64'h1);
    chk("hold_scnt",    bus_a.stall_cnt,     64'd3);
    chk("hold_no_wdog", bus_a.stall_timeout, 64'h0);
    step(1);
    chk("wdog_set",     bus_a.stall_timeout, 64'h1);
    chk("wdog_scnt",    bus_a.stall_cnt,     64'd4);

    drive(1'b1, 1'b0, 1'b0, 32'h108, 32'h0070_0193, 1'b1, 1'b0);
    step(1);
    chk("reload_pc",     bus_a.PC_out,        64'h108);
    chk("reload_state",  bus_a.state_out,     64'h0);
    chk("wdog_sticky",   bus_a.stall_timeout, 64'h1);

    drive(1'b1, 1'b0, 1'b1, 32'h10c, 32'h0080_0213, 1'b1, 1'b0);
    step(1);
    chk("bub_pc",    bus_a.PC_out,    64'h0);
    chk("bub_inst",  bus_a.inst_out,  64'h13);
    chk("bub_valid", bus_a.valid_out, 64'h0);
    chk("bub_state", bus_a.state_out, 64'h2);
    chk("bub_fcnt",  bus_a.flush_cnt, 64'd1);

    drive(1'b1, 1'b1, 1'b1, 32'h10c, 32'h0080_0213, 1'b1, 1'b0);
    step(1);
    chk("sf_state", bus_a.state_out, 64'h1);
    chk("sf_fcnt",  bus_a.flush_cnt, 64'd1);
    chk("sf_scnt",  bus_a.stall_cnt, 64'd5);
    chk("sf_pc",    bus_a.PC_out,    64'h0);

    drive(1'b1, 1'b0, 1'b0, 32'h10c, 32'h0080_0213, 1'b1, 1'b1);
    step(1);
    chk("clr_pc",      bus_a.PC_out,        64'h10c);
    chk("clr_scnt",    bus_a.stall_cnt,     64'h0);
    chk("clr_fcnt",    bus_a.flush_cnt,     64'h0);
    chk("clr_timeout", bus_a.stall_timeout, 64'h0);

    drive(1'b0, 1'b1, 1'b0, 32'h300, 32'h1111_1111, 1'b0, 1'b0);
    step(5);
    chk("frz_pc",    bus_a.PC_out,    64'h10c);
    chk("frz_valid", bus_a.valid_out, 64'h1);
    chk("frz_state", bus_a.state_out, 64'h0);
    chk("frz_scnt",  bus_a.stall_cnt, 64'h0);

    drive(1'b1, 1'b1, 1'b0, 32'h300, 32'h1111_1111, 1'b0, 1'b0);
    step(20);
    chk("sat_b_scnt",    bus_b.stall_cnt,     64'd15);
    chk("sat_b_timeout", bus_b.stall_timeout, 64'h1);
    chk("long_a_scnt",   bus_a.stall_cnt,     64'd20);
    chk("long_a_wdog",   bus_a.stall_timeout, 64'h1);
    chk("long_a_state",  bus_a.state_out,     64'h1);

    #2;
    rst = 1'b1;
    #1;
    chk("arst_pc",      bus_a.PC_out,        64'h0);
    chk("arst_inst",    bus_a.inst_out,      64'h13);
    chk("arst_valid",   bus_a.valid_out,     64'h0);
    chk("arst_state",   bus_a.state_out,     64'h0);
    chk("arst_scnt",    bus_a.stall_cnt,     64'h0);
    chk("arst_timeout", bus_a.stall_timeout, 64'h0);
    chk("arst_b_scnt",  bus_b.stall_cnt,     64'h0);
    step(1);
    rst = 1'b0;

    drive(1'b1, 1'b0, 1'b0, 32'h200, 32'h0090_0293, 1'b1, 1'b0);
    step(1);
    chk("post_pc",    bus_a.PC_out,    64'h200);
    chk("post_state", bus_a.state_out, 64'h0);
    chk("post_scnt",  bus_a.stall_cnt, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
